// File: rtl/instruction_fetch.sv
// Instruction fetch front end.
// Issues one word-aligned read at a time to instruction memory and queues
// returned words with their addresses in a 2-entry FIFO for decode. A
// redirect (taken branch/jump) flushes the queue and restarts fetch at
// redirect_pc. Any read already in flight when a redirect arrives is
// allowed to complete, and its data is thrown away.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   mem_req, mem_addr     instruction-memory read request and word address
//   mem_ack, mem_rdata    read completion and returned instruction word
//   redirect, redirect_pc control-flow change and new fetch address
//   inst_valid, inst,     head of the fetch queue presented to decode
//   inst_pc
//   inst_ready            decode accepts the head entry this cycle
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 2;
    localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);
    localparam logic [XLEN-1:0] RESET_PC_AL = RESET_PC & ALIGN_MASK;

    // IDLE: no request; REQ: request whose data is kept;
    // DRAIN: request whose data is discarded after a redirect.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_addr;
    logic [CW-1:0]   count;

    // Second FIFO entry; the head entry lives directly in inst/inst_pc.
    logic [XLEN-1:0] e1_pc;
    logic [XLEN-1:0] e1_word;

    logic            pop;
    logic            push;
    logic [CW-1:0]   count_pop;
    logic [CW-1:0]   count_nx;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] pc_inc;

    assign mem_addr = req_addr;

    // Queue movement and next-address helpers
    always_comb begin
        redir_pc  = redirect_pc & ALIGN_MASK;
        pc_inc    = fetch_pc + XLEN'(4);
        pop       = inst_valid & inst_ready & ~redirect;
        push      = (state == REQ) & mem_ack & ~redirect;
        count_pop = count - CW'(pop);
        count_nx  = count_pop + CW'(push);
        if (redirect) begin
            count_nx = '0;
        end
    end

    // Fetch FSM, fetch queue and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            fetch_pc   <= RESET_PC_AL;
            req_addr   <= RESET_PC_AL;
            count      <= '0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            e1_pc      <= '0;
            e1_word    <= '0;
        end else begin
            count      <= count_nx;
            inst_valid <= (count_nx != '0);

            // New word lands in the head slot when the queue is empty after
            // this cycle's pop, otherwise behind the head.
            if (push && (count_pop == '0)) begin
                inst_pc <= req_addr;
                inst    <= mem_rdata;
            end else if (pop) begin
                inst_pc <= e1_pc;
                inst    <= e1_word;
            end
            if (push && (count_pop != '0)) begin
                e1_pc   <= req_addr;
                e1_word <= mem_rdata;
            end

            case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= redir_pc;
                        req_addr <= redir_pc;
                        state    <= REQ;
                        mem_req  <= 1'b1;
                    end else if (count_pop < CW'(2)) begin
                        req_addr <= fetch_pc;
                        state    <= REQ;
                        mem_req  <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack && redirect) begin
                        fetch_pc <= redir_pc;
                        req_addr <= redir_pc;
                    end else if (mem_ack) begin
                        fetch_pc <= pc_inc;
                        if (count_nx < CW'(2)) begin
                            req_addr <= pc_inc;
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end else if (redirect) begin
                        // Request stays up until acked; its data is dropped.
                        fetch_pc <= redir_pc;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        fetch_pc <= redir_pc;
                    end
                    if (mem_ack) begin
                        state    <= REQ;
                        req_addr <= redirect ? redir_pc : fetch_pc;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int total = 0;
    int bad   = 0;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5EED_F00D;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ack;
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        x_req;
        logic [31:0] x_addr;
        logic        x_valid;
        logic [31:0] x_pc;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic ack, input logic rdy,
                                input logic rd, input logic [31:0] rpc,
                                input logic xr, input logic [31:0] xa,
                                input logic xv, input logic [31:0] xp);
        vec_t v;
        v.rst = rst; v.ack = ack; v.rdy = rdy; v.rd = rd; v.rpc = rpc;
        v.x_req = xr; v.x_addr = xa; v.x_valid = xv; v.x_pc = xp;
        return v;
    endfunction

    // Apply inputs now (at a falling edge), cross one rising edge, return at the next falling edge.
    task automatic step(input logic ack, input logic rdy, input logic rd,
                        input logic [31:0] rpc, input logic [31:0] rdata);
        mem_ack     = ack;
        inst_ready  = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        mem_rdata   = rdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Transaction-level reference: queue of fetched words plus the one outstanding read.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    ent_t        q[$];
    logic        m_req;
    logic        m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_pc;

    task automatic model_step(input logic ack, input logic [31:0] rdata, input logic rd,
                              input logic [31:0] rpc, input logic rdy);
        logic done;
        done = m_req && ack;
        if (q.size() > 0 && rdy && !rd) q.delete(0);
        if (rd) q.delete();
        if (done && !m_drop && !rd) begin
            q.push_back('{m_addr, rdata});
            m_pc = m_addr + 32'd4;
        end
        if (rd) m_pc = rpc & 32'hFFFF_FFFC;
        if (m_req && !done) begin
            if (rd) m_drop = 1'b1;
        end else if (done && m_drop) begin
            m_drop = 1'b0;
            m_addr = m_pc;
        end else begin
            m_req = (q.size() < 2);
            if (m_req) m_addr = m_pc;
        end
    endtask

    vec_t tbl[24];

    initial begin
        logic        a, r, d;
        logic [31:0] rp;
        logic [31:0] rw;

        reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0; redirect = 1'b0;
        redirect_pc = '0; inst_ready = 1'b0;

        //            rst   ack   rdy   rd    rpc           req   addr          valid pc
        tbl[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h0,       1'b0, 32'h0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h4,       1'b1, 32'h0);
        tbl[3]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h8,       1'b1, 32'h4);
        tbl[4]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'hC,       1'b1, 32'h8);
        // Decode stalled: two entries queue, request drops, then resumes at 0x8
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h0,       1'b0, 32'h0);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,       1'b1, 32'h4,       1'b1, 32'h0);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h0);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h8,       1'b1, 32'h4);
        tbl[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h8,       1'b0, 32'h0);
        tbl[12] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'hC,       1'b1, 32'h8);
        // Redirect coincident with ack
        tbl[13] = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h203,     1'b1, 32'h200,     1'b0, 32'h0);
        tbl[14] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h204,     1'b1, 32'h200);
        tbl[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h204,     1'b0, 32'h0);
        // Redirect while a request is pending, ack three cycles later
        tbl[16] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0);
        tbl[17] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h0,       1'b0, 32'h0);
        tbl[18] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h4,       1'b1, 32'h0);
        tbl[19] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h8,       1'b1, 32'h4);
        tbl[20] = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h100,     1'b1, 32'h8,       1'b0, 32'h0);
        tbl[21] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       1'b1, 32'h8,       1'b0, 32'h0);
        tbl[22] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h100,     1'b0, 32'h0);
        tbl[23] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h0,       1'b1, 32'h104,     1'b1, 32'h100);

        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            reset = tbl[i].rst;
            step(tbl[i].ack, tbl[i].rdy, tbl[i].rd, tbl[i].rpc, word_of(mem_addr));
            chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(tbl[i].x_req));
            if (tbl[i].x_req) chk($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].x_addr);
            chk($sformatf("v%0d inst_valid", i), 32'(inst_valid), 32'(tbl[i].x_valid));
            if (tbl[i].x_valid) begin
                chk($sformatf("v%0d inst_pc", i), inst_pc, tbl[i].x_pc);
                chk($sformatf("v%0d inst", i), inst, word_of(tbl[i].x_pc));
            end
            if (tbl[i].rst) begin
                chk($sformatf("v%0d rst inst_pc", i), inst_pc, 32'h0);
                chk($sformatf("v%0d rst inst", i), inst, 32'h0);
            end
        end

        // Address wrap: redirect to the last word, then fetch past it
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, word_of(mem_addr));
        chk("wrap redirect addr", mem_addr, 32'hFFFF_FFFC);
        chk("wrap redirect valid", 32'(inst_valid), 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0, word_of(mem_addr));
        chk("wrap next addr", mem_addr, 32'h0000_0000);
        chk("wrap inst_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wrap inst", inst, word_of(32'hFFFF_FFFC));
        step(1'b1, 1'b1, 1'b0, 32'h0, word_of(mem_addr));
        chk("wrap inst_pc 0", inst_pc, 32'h0);
        chk("wrap addr 4", mem_addr, 32'h4);

        // Reset while a request is up and the queue holds an entry
        mem_ack = 1'b0; inst_ready = 1'b0;
        chk("pre-reset mem_req", 32'(mem_req), 32'h1);
        chk("pre-reset valid", 32'(inst_valid), 32'h1);
        reset = 1'b1;
        #1;
        chk("async reset mem_req", 32'(mem_req), 32'h0);
        chk("async reset valid", 32'(inst_valid), 32'h0);
        chk("async reset inst_pc", inst_pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post-reset idle", 32'(mem_req), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("post-reset req", 32'(mem_req), 32'h1);
        chk("post-reset addr", mem_addr, 32'h0);

        // Randomised traffic against the reference model
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        q.delete();
        m_req = 1'b0; m_drop = 1'b0; m_addr = 32'h0; m_pc = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            a  = m_req && ($urandom_range(0, 2) != 0);
            r  = ($urandom_range(0, 3) != 0);
            d  = ($urandom_range(0, 15) == 0);
            rp = $urandom;
            if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            rw = $urandom;
            model_step(a, rw, d, rp, r);
            step(a, r, d, rp, rw);
            chk("rnd mem_req", 32'(mem_req), 32'(m_req));
            if (m_req) chk("rnd mem_addr", mem_addr, m_addr);
            chk("rnd inst_valid", 32'(inst_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("rnd inst_pc", inst_pc, q[0].pc);
                chk("rnd inst", inst, q[0].w);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
